// File: rtl/lcd_pkg.sv
// Shared opcodes, idle word, init-table length and state encoding for the
// ST7735 init/clear sequencer.
package lcd_pkg;

    localparam logic [7:0] CMD_SLPOUT = 8'h11;
    localparam logic [7:0] CMD_CASET  = 8'h2A;
    localparam logic [7:0] CMD_RASET  = 8'h2B;
    localparam logic [7:0] CMD_RAMWR  = 8'h2C;
    localparam logic [7:0] CMD_MADCTL = 8'h36;
    localparam logic [7:0] CMD_COLMOD = 8'h3A;
    localparam logic [7:0] CMD_DISPON = 8'h29;

    localparam logic [8:0] DATA_IDLE = 9'h100;
    localparam int         INIT_LEN  = 73;

    typedef enum logic [2:0] {
        RST_LOW,
        RST_HIGH,
        WR_SLPOUT,
        SLP_WAIT,
        WR_INIT,
        WR_WIN,
        WR_PIX,
        IDLE
    } lcd_state_e;

endpackage

// File: rtl/lcd_init_rom.sv
// Init command table: frame rate, power, MADCTL, gamma, colour mode, display on.
// bit8 = 1 marks a data byte, 0 a command.
module lcd_init_rom
    import lcd_pkg::*;
#(
    parameter logic [7:0] MADCTL = 8'h60
) (
    input  logic [6:0] addr,
    output logic [8:0] rom_word
);

    localparam int MADCTL_ADDR = 35;

    // Entry at MADCTL_ADDR is overridden by the MADCTL parameter.
    localparam logic [8:0] TBL [INIT_LEN] = '{
        9'h0B1, 9'h101, 9'h12C, 9'h12D,
        9'h0B2, 9'h101, 9'h12C, 9'h12D,
        9'h0B3, 9'h101, 9'h12C, 9'h12D, 9'h101, 9'h12C, 9'h12D,
        9'h0B4, 9'h107,
        9'h0C0, 9'h1A2, 9'h102, 9'h184,
        9'h0C1, 9'h1C5,
        9'h0C2, 9'h10A, 9'h100,
        9'h0C3, 9'h18A, 9'h12A,
        9'h0C4, 9'h18A, 9'h1EE,
        9'h0C5, 9'h10E,
        {1'b0, CMD_MADCTL}, DATA_IDLE,
        9'h0E0, 9'h102, 9'h11C, 9'h107, 9'h112, 9'h137, 9'h132, 9'h129, 9'h12D,
                9'h129, 9'h125, 9'h12B, 9'h139, 9'h100, 9'h101, 9'h103, 9'h110,
        9'h0E1, 9'h103, 9'h11D, 9'h107, 9'h106, 9'h12E, 9'h12C, 9'h129, 9'h12D,
                9'h12E, 9'h12E, 9'h137, 9'h13F, 9'h100, 9'h100, 9'h102, 9'h110,
        {1'b0, CMD_COLMOD}, 9'h105,
        {1'b0, CMD_DISPON}
    };

    always_comb begin
        rom_word = DATA_IDLE;
        if (addr == 7'(MADCTL_ADDR))
            rom_word = {1'b1, MADCTL};
        else if (addr < 7'(INIT_LEN))
            rom_word = TBL[addr];
    end

endmodule

// File: rtl/lcd_init_seq.sv
// ST7735 power-up sequencer: reset/sleep-out delays, init table, banded
// background, then resident rectangle fills via fill_req/fill_ack.
module lcd_init_seq
    import lcd_pkg::*;
#(
    parameter int         T_RST_LOW  = 1_000_000,
    parameter int         T_RST_HIGH = 1_000_000,
    parameter int         T_SLPOUT   = 250_000,
    parameter int         WIDTH      = 162,
    parameter int         HEIGHT     = 132,
    parameter int         XOFF       = 0,
    parameter int         YOFF       = 0,
    parameter logic [7:0] MADCTL     = 8'h60,
    parameter int         NUM_BANDS  = 4
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst_n,
    input  logic                      wr_done,
    input  logic [8*NUM_BANDS-1:0]    band_end_row,
    input  logic [16*NUM_BANDS-1:0]   band_color,
    input  logic                      fill_req,
    input  logic [7:0]                fill_x0,
    input  logic [7:0]                fill_y0,
    input  logic [7:0]                fill_x1,
    input  logic [7:0]                fill_y1,
    input  logic [15:0]               fill_color,
    output logic                      lcd_rst,
    output logic [8:0]                init_data,
    output logic                      en_write,
    output logic                      init_done,
    output logic                      fill_ack,
    output logic                      fill_err,
    output logic                      fill_busy
);

    localparam logic [7:0] X_MAX = 8'(WIDTH - 1);
    localparam logic [7:0] Y_MAX = 8'(HEIGHT - 1);

    lcd_state_e  state, state_nxt;
    logic [23:0] cnt, cnt_nxt;
    logic [6:0]  rom_addr, rom_addr_nxt;
    logic [3:0]  win_idx, win_idx_nxt;
    logic [7:0]  col, col_nxt, row, row_nxt;
    logic [7:0]  x0, x0_nxt, y0, y0_nxt, x1, x1_nxt, y1, y1_nxt;
    logic [15:0] fill_rgb, fill_rgb_nxt, band_rgb, pix_rgb;
    logic        fill_mode, fill_mode_nxt, byte_hi, byte_hi_nxt;
    logic        init_done_nxt, fill_busy_nxt, fill_ack_nxt, fill_err_nxt;
    logic [8:0]  data_nxt, rom_word;
    logic [7:0]  req_x1, req_y1;
    logic        req_bad;

    lcd_init_rom #(.MADCTL(MADCTL)) u_rom (
        .addr     (rom_addr_nxt),
        .rom_word (rom_word)
    );

    function automatic logic [8:0] win_word(input logic [3:0] idx, input logic [7:0] a0,
                                            input logic [7:0] b0, input logic [7:0] a1,
                                            input logic [7:0] b1);
        case (idx)
            4'd0:    return {1'b0, CMD_CASET};
            4'd2:    return {1'b1, a0 + 8'(XOFF)};
            4'd4:    return {1'b1, a1 + 8'(XOFF)};
            4'd5:    return {1'b0, CMD_RASET};
            4'd7:    return {1'b1, b0 + 8'(YOFF)};
            4'd9:    return {1'b1, b1 + 8'(YOFF)};
            4'd10:   return {1'b0, CMD_RAMWR};
            default: return DATA_IDLE;
        endcase
    endfunction

    assign lcd_rst  = (state != RST_LOW);
    assign en_write = (state inside {WR_SLPOUT, WR_INIT, WR_WIN, WR_PIX});

    assign req_x1  = (fill_x1 > X_MAX) ? X_MAX : fill_x1;
    assign req_y1  = (fill_y1 > Y_MAX) ? Y_MAX : fill_y1;
    assign req_bad = (fill_x0 > req_x1) || (fill_y0 > req_y1);

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state     <= RST_LOW;
            cnt       <= '0;
            rom_addr  <= '0;
            win_idx   <= '0;
            col       <= '0;
            row       <= '0;
            x0        <= '0;
            y0        <= '0;
            x1        <= '0;
            y1        <= '0;
            fill_rgb  <= '0;
            fill_mode <= 1'b0;
            byte_hi   <= 1'b1;
            init_data <= DATA_IDLE;
            init_done <= 1'b0;
            fill_busy <= 1'b0;
            fill_ack  <= 1'b0;
            fill_err  <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            rom_addr  <= rom_addr_nxt;
            win_idx   <= win_idx_nxt;
            col       <= col_nxt;
            row       <= row_nxt;
            x0        <= x0_nxt;
            y0        <= y0_nxt;
            x1        <= x1_nxt;
            y1        <= y1_nxt;
            fill_rgb  <= fill_rgb_nxt;
            fill_mode <= fill_mode_nxt;
            byte_hi   <= byte_hi_nxt;
            init_data <= data_nxt;
            init_done <= init_done_nxt;
            fill_busy <= fill_busy_nxt;
            fill_ack  <= fill_ack_nxt;
            fill_err  <= fill_err_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        rom_addr_nxt  = rom_addr;
        win_idx_nxt   = win_idx;
        col_nxt       = col;
        row_nxt       = row;
        x0_nxt        = x0;
        y0_nxt        = y0;
        x1_nxt        = x1;
        y1_nxt        = y1;
        fill_rgb_nxt  = fill_rgb;
        fill_mode_nxt = fill_mode;
        byte_hi_nxt   = byte_hi;
        init_done_nxt = init_done;
        fill_busy_nxt = fill_busy;
        fill_ack_nxt  = 1'b0;
        fill_err_nxt  = 1'b0;
        case (state)
            RST_LOW: begin
                cnt_nxt = cnt + 24'd1;
                if (cnt == 24'(T_RST_LOW - 1)) begin
                    state_nxt = RST_HIGH;
                    cnt_nxt   = '0;
                end
            end
            RST_HIGH: begin
                cnt_nxt = cnt + 24'd1;
                if (cnt == 24'(T_RST_HIGH - 1)) begin
                    state_nxt = WR_SLPOUT;
                    cnt_nxt   = '0;
                end
            end
            WR_SLPOUT: if (wr_done) state_nxt = SLP_WAIT;
            SLP_WAIT: begin
                cnt_nxt = cnt + 24'd1;
                if (cnt == 24'(T_SLPOUT - 1)) begin
                    state_nxt    = WR_INIT;
                    cnt_nxt      = '0;
                    rom_addr_nxt = '0;
                end
            end
            WR_INIT: if (wr_done) begin
                if (rom_addr == 7'(INIT_LEN - 1)) begin
                    state_nxt     = WR_WIN;
                    win_idx_nxt   = '0;
                    x0_nxt        = '0;
                    y0_nxt        = '0;
                    x1_nxt        = X_MAX;
                    y1_nxt        = Y_MAX;
                    fill_mode_nxt = 1'b0;
                end else begin
                    rom_addr_nxt = rom_addr + 7'd1;
                end
            end
            WR_WIN: if (wr_done) begin
                if (win_idx == 4'd10) begin
                    state_nxt   = WR_PIX;
                    col_nxt     = x0;
                    row_nxt     = y0;
                    byte_hi_nxt = 1'b1;
                end else begin
                    win_idx_nxt = win_idx + 4'd1;
                end
            end
            WR_PIX: if (wr_done) begin
                byte_hi_nxt = ~byte_hi;
                if (!byte_hi) begin
                    if (col != x1) begin
                        col_nxt = col + 8'd1;
                    end else if (row != y1) begin
                        col_nxt = x0;
                        row_nxt = row + 8'd1;
                    end else begin
                        state_nxt = IDLE;
                        if (fill_mode) fill_busy_nxt = 1'b0;
                        else           init_done_nxt = 1'b1;
                    end
                end
            end
            IDLE: if (fill_req) begin
                if (req_bad) begin
                    fill_err_nxt = 1'b1;
                end else begin
                    fill_ack_nxt  = 1'b1;
                    fill_busy_nxt = 1'b1;
                    fill_mode_nxt = 1'b1;
                    state_nxt     = WR_WIN;
                    win_idx_nxt   = '0;
                    x0_nxt        = fill_x0;
                    y0_nxt        = fill_y0;
                    x1_nxt        = req_x1;
                    y1_nxt        = req_y1;
                    fill_rgb_nxt  = fill_color;
                end
            end
            default: state_nxt = RST_LOW;
        endcase
    end

    // Earliest band whose end row covers the row; rows past every end fall to the last band.
    always_comb begin
        band_rgb = band_color[16*NUM_BANDS-1 -: 16];
        for (int i = NUM_BANDS - 1; i >= 0; i--)
            if (row_nxt <= band_end_row[8*i +: 8]) band_rgb = band_color[16*i +: 16];
    end

    assign pix_rgb = fill_mode_nxt ? fill_rgb_nxt : band_rgb;

    always_comb begin
        case (state_nxt)
            WR_SLPOUT: data_nxt = {1'b0, CMD_SLPOUT};
            WR_INIT:   data_nxt = rom_word;
            WR_WIN:    data_nxt = win_word(win_idx_nxt, x0_nxt, y0_nxt, x1_nxt, y1_nxt);
            WR_PIX:    data_nxt = {1'b1, byte_hi_nxt ? pix_rgb[15:8] : pix_rgb[7:0]};
            default:   data_nxt = DATA_IDLE;
        endcase
    end

endmodule

// File: tb/tb_lcd_init_seq.sv
// Bench for lcd_init_seq: writer model, byte-stream reference model, directed
// and randomized rectangle fills, mid-stream reset.
module tb_lcd_init_seq;

    localparam int W = 4, H = 3, XO = 2, YO = 1, NB = 2;

    logic              sys_clk = 1'b0;
    logic              sys_rst_n = 1'b0;
    logic              wr_done = 1'b0;
    logic [8*NB-1:0]   band_end_row = {8'd2, 8'd0};
    logic [16*NB-1:0]  band_color = {16'h001F, 16'hF800};
    logic              fill_req = 1'b0;
    logic [7:0]        fill_x0 = '0, fill_y0 = '0, fill_x1 = '0, fill_y1 = '0;
    logic [15:0]       fill_color = '0;
    logic              lcd_rst, en_write, init_done, fill_ack, fill_err, fill_busy;
    logic [8:0]        init_data;

    lcd_init_seq #(
        .T_RST_LOW(10), .T_RST_HIGH(10), .T_SLPOUT(5), .WIDTH(W), .HEIGHT(H),
        .XOFF(XO), .YOFF(YO), .MADCTL(8'h60), .NUM_BANDS(NB)
    ) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .wr_done(wr_done),
        .band_end_row(band_end_row), .band_color(band_color),
        .fill_req(fill_req), .fill_x0(fill_x0), .fill_y0(fill_y0),
        .fill_x1(fill_x1), .fill_y1(fill_y1), .fill_color(fill_color),
        .lcd_rst(lcd_rst), .init_data(init_data), .en_write(en_write),
        .init_done(init_done), .fill_ack(fill_ack), .fill_err(fill_err),
        .fill_busy(fill_busy)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int n_vec = 0, n_err = 0;
    int wr_lat = 3, wr_wait = 0, last_done_cyc = 0;
    bit spurious_on = 1'b0;
    logic [8:0] sent[$];
    logic [8:0] exp_q[$];

    logic [8:0] rom_q[$] = '{
        9'h0B1, 9'h101, 9'h12C, 9'h12D, 9'h0B2, 9'h101, 9'h12C, 9'h12D,
        9'h0B3, 9'h101, 9'h12C, 9'h12D, 9'h101, 9'h12C, 9'h12D,
        9'h0B4, 9'h107, 9'h0C0, 9'h1A2, 9'h102, 9'h184, 9'h0C1, 9'h1C5,
        9'h0C2, 9'h10A, 9'h100, 9'h0C3, 9'h18A, 9'h12A, 9'h0C4, 9'h18A, 9'h1EE,
        9'h0C5, 9'h10E, 9'h036, 9'h160,
        9'h0E0, 9'h102, 9'h11C, 9'h107, 9'h112, 9'h137, 9'h132, 9'h129, 9'h12D,
        9'h129, 9'h125, 9'h12B, 9'h139, 9'h100, 9'h101, 9'h103, 9'h110,
        9'h0E1, 9'h103, 9'h11D, 9'h107, 9'h106, 9'h12E, 9'h12C, 9'h129, 9'h12D,
        9'h12E, 9'h12E, 9'h137, 9'h13F, 9'h100, 9'h100, 9'h102, 9'h110,
        9'h03A, 9'h105, 9'h029
    };

    // Byte writer: wr_done wr_lat cycles after each byte; optional stray pulses while idle.
    initial begin
        forever begin
            @(negedge sys_clk);
            if (wr_done) begin
                wr_done = 1'b0;
            end else if (en_write) begin
                wr_wait++;
                if (wr_wait >= wr_lat) begin
                    wr_done = 1'b1;
                    sent.push_back(init_data);
                    last_done_cyc = cyc;
                    wr_wait = 0;
                end
            end else begin
                wr_wait = 0;
                if (spurious_on && $urandom_range(0, 2) == 0) wr_done = 1'b1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge sys_clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk(tag, {lcd_rst, init_data, en_write, init_done, fill_ack, fill_err, fill_busy},
            {1'b0, 9'h100, 5'b0});
    endtask

    function automatic logic [15:0] band_of(input int r);
        for (int i = 0; i < NB; i++)
            if (r <= int'(band_end_row[8*i +: 8])) return band_color[16*i +: 16];
        return band_color[16*NB-1 -: 16];
    endfunction

    function automatic void push_window(input logic [7:0] a0, input logic [7:0] b0,
                                        input logic [7:0] a1, input logic [7:0] b1);
        logic [7:0] xa, xb, ya, yb;
        xa = a0 + 8'(XO); xb = a1 + 8'(XO);
        ya = b0 + 8'(YO); yb = b1 + 8'(YO);
        exp_q.push_back(9'h02A); exp_q.push_back(9'h100); exp_q.push_back({1'b1, xa});
        exp_q.push_back(9'h100); exp_q.push_back({1'b1, xb});
        exp_q.push_back(9'h02B); exp_q.push_back(9'h100); exp_q.push_back({1'b1, ya});
        exp_q.push_back(9'h100); exp_q.push_back({1'b1, yb});
        exp_q.push_back(9'h02C);
    endfunction

    function automatic void push_pixels(input int a0, input int b0, input int a1, input int b1,
                                        input bit use_fill, input logic [15:0] rgb_in);
        logic [15:0] rgb;
        for (int r = b0; r <= b1; r++)
            for (int c = a0; c <= a1; c++) begin
                rgb = use_fill ? rgb_in : band_of(r);
                exp_q.push_back({1'b1, rgb[15:8]});
                exp_q.push_back({1'b1, rgb[7:0]});
            end
    endfunction

    task automatic compare_stream(input string tag);
        int n;
        chk({tag, "_len"}, sent.size(), exp_q.size());
        n = (sent.size() < exp_q.size()) ? sent.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s[%0d]", tag, i), sent[i], exp_q[i]);
    endtask

    task automatic run_init();
        int n;
        sent.delete();
        n = 0;
        do begin tick(); n++; end while (!lcd_rst && n < 100);
        chk("rst_low_cycles", n, 10);
        spurious_on = 1'b1;
        n = 0;
        while (!en_write && n < 100) begin n++; tick(); end
        spurious_on = 1'b0;
        chk("rst_high_cycles", n, 10);
        chk("slpout_word", init_data, 9'h011);
        n = 0;
        while (sent.size() == 0 && n < 50) begin n++; tick(); end
        chk("slpout_tmo", n < 50, 1);
        tick();
        n = 0;
        while (!en_write && n < 100) begin n++; tick(); end
        chk("slp_wait_cycles", n, 5);
        chk("rom_word0", init_data, rom_q[0]);
        n = 0;
        while (!init_done && n < 20000) begin n++; tick(); end
        chk("init_tmo", n < 20000, 1);
        chk("init_done_lat", cyc - last_done_cyc, 1);
        chk("busy_after_init", fill_busy, 0);
        exp_q.delete();
        exp_q.push_back(9'h011);
        foreach (rom_q[i]) exp_q.push_back(rom_q[i]);
        push_window(8'd0, 8'd0, 8'(W - 1), 8'(H - 1));
        push_pixels(0, 0, W - 1, H - 1, 1'b0, 16'h0);
        compare_stream("init");
    endtask

    task automatic do_fill(input logic [7:0] a0, input logic [7:0] b0, input logic [7:0] a1,
                           input logic [7:0] b1, input logic [15:0] rgb);
        int n;
        logic [7:0] ca1, cb1;
        bit bad;
        ca1 = (a1 > 8'(W - 1)) ? 8'(W - 1) : a1;
        cb1 = (b1 > 8'(H - 1)) ? 8'(H - 1) : b1;
        bad = (a0 > ca1) || (b0 > cb1);
        chk("idle_word", init_data, 9'h100);
        sent.delete();
        fill_x0 = a0; fill_y0 = b0; fill_x1 = a1; fill_y1 = b1; fill_color = rgb;
        fill_req = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!fill_ack && !fill_err && n < 20);
        fill_req = 1'b0;
        chk("fill_ack", fill_ack, !bad);
        chk("fill_err", fill_err, bad);
        if (bad) begin
            tick();
            chk("err_pulse_width", fill_err, 0);
            repeat (4) tick();
            chk("err_no_write", {en_write, fill_busy, sent.size() != 0}, 3'b000);
        end else begin
            chk("busy_set", fill_busy, 1);
            n = 0;
            while (fill_busy && n < 5000) begin n++; tick(); end
            chk("fill_tmo", n < 5000, 1);
            chk("init_done_held", init_done, 1);
            exp_q.delete();
            push_window(a0, b0, ca1, cb1);
            push_pixels(int'(a0), int'(b0), int'(ca1), int'(cb1), 1'b1, rgb);
            compare_stream("fill");
        end
    endtask

    initial begin
        int n;
        repeat (3) tick();
        chk_reset("por");
        sys_rst_n = 1'b1;
        run_init();

        do_fill(8'd1, 8'd1, 8'd2, 8'd1, 16'h07E0);
        do_fill(8'd3, 8'd0, 8'd1, 8'd2, 16'h1234);
        do_fill(8'd0, 8'd0, 8'd9, 8'd0, 16'hABCD);

        // Abort mid-pixel-stream, then restart the whole sequence.
        fill_x0 = 8'd0; fill_y0 = 8'd0; fill_x1 = 8'd3; fill_y1 = 8'd2; fill_color = 16'h5555;
        sent.delete();
        fill_req = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!fill_ack && n < 20);
        fill_req = 1'b0;
        n = 0;
        while (sent.size() < 14 && n < 500) begin n++; tick(); end
        chk("pix_reach_tmo", n < 500, 1);
        sys_rst_n = 1'b0;
        tick();
        chk_reset("mid_reset");
        tick();
        chk_reset("reset_hold");
        sys_rst_n = 1'b1;
        run_init();

        spurious_on = 1'b1;
        repeat (12) begin
            wr_lat = $urandom_range(1, 4);
            repeat ($urandom_range(1, 6)) tick();
            do_fill(8'($urandom_range(0, 4)), 8'($urandom_range(0, 3)),
                    8'($urandom_range(0, 6)), 8'($urandom_range(0, 4)), 16'($urandom));
        end
        spurious_on = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lcd_init_seq.md
Name: lcd_init_seq

Overview:
Parametrised successor to the ST7735 SPI-LCD init/clear sequencer. It drives the panel reset and sleep-out delays, then streams a ROM init table and a full-screen banded background (up to 8 horizontal colour bands).
After init it stays resident and serves run-time rectangle-fill requests through a req/ack handshake.
It feeds 9-bit {dc, byte} words to the existing SPI byte writer, which returns a one-cycle wr_done per byte.

Parameters:
T_RST_LOW, 1_000_000, cycles lcd_rst held low after reset
T_RST_HIGH, 1_000_000, cycles after lcd_rst rises before SLPOUT
T_SLPOUT, 250_000, cycles after SLPOUT before init table
WIDTH, 162, visible columns (1..256)
HEIGHT, 132, visible rows (1..256)
XOFF, 0, column offset added to every 0x2A address
YOFF, 0, row offset added to every 0x2B address
MADCTL, 8'h60, data byte sent after 0x36 in the init table
NUM_BANDS, 4, background bands (1..8)

Ports:
sys_clk  in  1  system clock
sys_rst_n  in  1  synchronous active-low reset
wr_done  in  1  writer pulse: current byte sent
band_end_row  in  8*NUM_BANDS  last row of band i (ascending), stable from reset until init_done
band_color  in  16*NUM_BANDS  RGB565 colour of band i
fill_req  in  1  level; rectangle fill request
fill_x0, fill_y0, fill_x1, fill_y1  in  8 each  inclusive rectangle, visible coordinates
fill_color  in  16  RGB565 fill colour
lcd_rst  out  1  panel reset
init_data  out  9  bit8=1 data, 0 command; idle 9'h100
en_write  out  1  writer enable
init_done  out  1  initial sequence complete
fill_ack  out  1  one-cycle pulse on request acceptance
fill_err  out  1  one-cycle pulse on request rejection
fill_busy  out  1  accepted fill in progress

Behaviour:
- Reset (sys_clk edge with sys_rst_n=0, including mid-operation): state=RST_LOW, counters cleared; lcd_rst=0, init_data=9'h100, en_write=0, init_done=0, fill_ack=0, fill_err=0, fill_busy=0. The whole sequence restarts.
- FSM states: RST_LOW, RST_HIGH, WR_SLPOUT, SLP_WAIT, WR_INIT, WR_WIN, WR_PIX, IDLE.
- Delay counter: 24 bits.
  - RST_LOW lasts exactly T_RST_LOW cycles; lcd_rst rises on the transition to RST_HIGH.
  - RST_HIGH lasts exactly T_RST_HIGH cycles.
  - SLP_WAIT lasts exactly T_SLPOUT cycles.
- Byte protocol:
  - en_write=1 exactly in WR_SLPOUT, WR_INIT, WR_WIN, WR_PIX.
  - init_data is registered and holds until wr_done. The next byte appears the cycle after wr_done.
  - wr_done outside en_write is ignored.
- WR_SLPOUT sends 9'h011 and moves to SLP_WAIT on wr_done.
- WR_INIT walks the ROM at addresses 0..INIT_LEN-1; after the last wr_done it loads the full-screen window (0,0)-(WIDTH-1,HEIGHT-1), band mode.
- WR_WIN sends 11 words: 0x2A,00,x0+XOFF,00,x1+XOFF, 0x2B,00,y0+YOFF,00,y1+YOFF, 0x2C. Offsets use 8-bit wrap arithmetic.
- WR_PIX:
  - Column/row counters, no multiplier. Per pixel, send colour[15:8] then [7:0], both with dc=1.
  - Band mode colour = first band i with row ≤ band_end_row[i]; rows past the last end use band NUM_BANDS-1. Fill mode colour = fill_color.
  - After the lo byte of (x1,y1): from init → IDLE, init_done=1 (sticky until reset); from fill → IDLE, fill_busy=0.
- IDLE: init_data=9'h100. If fill_req=1:
  - Clamp x1 to WIDTH-1 and y1 to HEIGHT-1.
  - If x0>x1 or y0>y1 (after clamp): fill_err pulses, stay IDLE.
  - Otherwise fill_ack pulses, the request is latched, fill_busy=1, and the FSM enters WR_WIN the next cycle.
  - fill_req before init_done is not serviced until IDLE. The requester must drop fill_req after ack/err.

Decomposition:
- Package lcd_pkg: command opcodes (SLPOUT 0x11, CASET 0x2A, RASET 0x2B, RAMWR 0x2C, MADCTL 0x36, COLMOD 0x3A, DISPON 0x29), DATA_IDLE 9'h100, state encoding, INIT_LEN.
- Sub-module lcd_init_rom: combinational addr→9-bit word with MADCTL parameter passthrough. Table: B1/B2/B3 frame rate, B4, C0–C5 power, 36/MADCTL, E0/E1 gamma, 3A/05, 29.

Test Plan:
Common setup: T_RST_LOW=10, T_RST_HIGH=10, T_SLPOUT=5, WIDTH=4, HEIGHT=3, XOFF=2, YOFF=1, NUM_BANDS=2, band_end_row={2,0}, band_color={001F,F800}. Writer model pulses wr_done 3 cycles after each byte.
1. Reset release → lcd_rst low exactly 10 cycles; first en_write word 9'h011; 5 idle cycles before ROM word 0.
2. After the ROM, window words 02A,100,102,100,105,02B,100,101,100,103,02C; then 4×(1F8,100) for row 0 and 8×(100,11F) for rows 1–2; init_done rises the cycle after the 24th pixel-byte wr_done.
3. Fill x0=1,y0=1,x1=2,y1=1, color 07E0 → fill_ack pulse; window 02A,100,103,100,104,02B,100,102,100,102,02C; then 107,1E0,107,1E0; fill_busy falls; init_done stays 1.
4. Fill x0=3,x1=1 → fill_err single pulse, en_write stays 0. Fill x1=9,y1=0 → clamped window column end byte 105.
5. Assert sys_rst_n=0 mid-WR_PIX → next edge all outputs at reset values; after release the sequence restarts from RST_LOW.
6. Spurious wr_done pulses during RST_HIGH/IDLE → no pointer advance, stream bytes unchanged.
